// File: rtl/scancode_display_pkg.sv
// Shared definitions for the scancode display: hex glyph table, break code and break FSM states.
package scancode_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g; "b" and "d" are lower-case.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    S_IDLE,
    S_BREAK
  } brk_state_t;

endpackage

// File: rtl/scancode_display_if.sv
// Byte-input and display-output bundle of the scancode display.
interface scancode_display_if #(
  parameter int ND = 4
);
  logic          data_valid;
  logic [7:0]    data_in;
  logic          clear;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [7:0]    byte_count;

  modport master (
    output data_valid, data_in, clear,
    input  seg, an, byte_count
  );

  modport slave (
    input  data_valid, data_in, clear,
    output seg, an, byte_count
  );
endinterface

// File: rtl/scancode_display_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import scancode_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_hex];
endmodule

// File: rtl/scancode_display.sv
// Keeps the last NBYTES scancode bytes and scans them as hex onto a multiplexed 7-segment display.
// Define SCANCODE_BREAK_FILTER_EN to drop 0xF0 break prefixes and the byte that follows each one.
module scancode_display
  import scancode_pkg::*;
#(
  parameter int NBYTES   = 2,
  parameter int SCAN_DIV = 50000
) (
  input logic              FPGA_clock,
  input logic              rst,
  scancode_display_if.slave bus
);

  localparam int ND = 2 * NBYTES;
  localparam int HW = NBYTES * 8;
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(ND);

  logic [HW-1:0] r_hist;
  logic [7:0]    r_count;
  logic [PW-1:0] r_prescale;
  logic [DW-1:0] r_digit;
  logic [6:0]    r_seg;
  logic [ND-1:0] r_an;

  logic          w_store;
  logic          w_terminal;
  logic [DW-1:0] w_digitNext;
  logic [HW-1:0] w_histShifted;
  logic [HW-1:0] w_histDigit;
  logic [6:0]    w_glyph;

`ifdef SCANCODE_BREAK_FILTER_EN
  brk_state_t r_state;
  brk_state_t w_stateNext;

  always_ff @(posedge FPGA_clock or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (bus.clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A 0xF0 arms the filter; the first non-0xF0 byte after it is swallowed and disarms it.
  always_comb begin
    w_stateNext = r_state;
    w_store     = 1'b0;
    if (bus.data_valid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.data_in == BREAK_CODE) begin
            w_stateNext = S_BREAK;
          end else begin
            w_store = 1'b1;
          end
        end
        S_BREAK: begin
          if (bus.data_in != BREAK_CODE) begin
            w_stateNext = S_IDLE;
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end
  end
`else
  assign w_store = bus.data_valid;
`endif

  assign w_histShifted = (r_hist << 8) | HW'(bus.data_in);

  always_ff @(posedge FPGA_clock or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_count <= '0;
    end else if (bus.clear) begin
      r_hist  <= '0;
      r_count <= '0;
    end else if (w_store) begin
      r_hist <= w_histShifted;
      if (r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign w_terminal  = (r_prescale == PW'(SCAN_DIV - 1));
  assign w_digitNext = !w_terminal ? r_digit :
                       (r_digit == DW'(ND - 1)) ? '0 : r_digit + 1'b1;

  always_ff @(posedge FPGA_clock or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
      r_digit    <= '0;
    end else begin
      r_prescale <= w_terminal ? '0 : r_prescale + 1'b1;
      r_digit    <= w_digitNext;
    end
  end

  // seg and an both load from w_digitNext so the glyph and its enable always change on the same edge.
  assign w_histDigit = r_hist >> {w_digitNext, 2'b00};

  hex7seg u_hex7seg (
    .i_hex (w_histDigit[3:0]),
    .o_seg (w_glyph)
  );

  always_ff @(posedge FPGA_clock or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_TABLE[0];
      r_an  <= ~ND'(1);
    end else begin
      r_seg <= w_glyph;
      r_an  <= ~(ND'(1) << w_digitNext);
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.byte_count = r_count;

endmodule

// File: tb/tb_scancode_display.sv
// Scoreboard bench for scancode_display (NBYTES=2, SCAN_DIV=4) with a byte-level reference model.
module tb_scancode_display;

  localparam int NBYTES   = 2;
  localparam int SCAN_DIV = 4;
  localparam int ND       = 2 * NBYTES;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  scancode_display_if #(.ND(ND)) bus ();

  scancode_display #(
    .NBYTES   (NBYTES),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .FPGA_clock (clock),
    .rst        (reset),
    .bus        (bus)
  );

  typedef struct packed {
    int          due;
    logic [15:0] val;
  } item_t;

  item_t histQ[$];
  item_t countQ[$];

  int checks    = 0;
  int failures  = 0;
  int edgeCount = 0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [15:0] mHist    = '0;
  int          mCount   = 0;
  bit          mBreak   = 1'b0;
  logic [15:0] expHist  = '0;
  logic [7:0]  expCount = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) edgeCount <= 0;
    else       edgeCount <= edgeCount + 1;
  end

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 20)
        $display("[TB] FAIL %s edge=%0d got=%0h expected=%0h", name, edgeCount, got, exp);
    end
  endtask

  // Reference model: one call per sampling edge, results queued with the edge they become visible.
  task automatic modelEdge(input bit v, input logic [7:0] d, input bit c, input int e);
    bit keep;
    keep = 1'b1;
    if (c) begin
      mHist  = '0;
      mCount = 0;
      mBreak = 1'b0;
    end else if (v) begin
`ifdef SCANCODE_BREAK_FILTER_EN
      if (mBreak) begin
        keep = 1'b0;
        if (d != 8'hF0) mBreak = 1'b0;
      end else if (d == 8'hF0) begin
        keep   = 1'b0;
        mBreak = 1'b1;
      end
`endif
      if (keep) begin
        mHist = {mHist[7:0], d};
        if (mCount < 255) mCount++;
      end
    end
    countQ.push_back('{due: e, val: 16'(mCount)});
    histQ.push_back('{due: e + 1, val: mHist});
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit c);
    @(negedge clock);
    bus.data_valid = v;
    bus.data_in    = d;
    bus.clear      = c;
    modelEdge(v, d, c, edgeCount + 1);
  endtask

  task automatic flushModel();
    histQ.delete();
    countQ.delete();
    mHist    = '0;
    mCount   = 0;
    mBreak   = 1'b0;
    expHist  = '0;
    expCount = '0;
  endtask

  task automatic doReset();
    @(negedge clock);
    #2 reset = 1'b1;
    flushModel();
    #20;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: the display presents a digit every cycle; compare it against the scan position and model.
  always @(negedge clock) begin
    item_t      it;
    int         expDigit;
    logic [3:0] expAn;
    logic [3:0] nib;
    if (!reset) begin
      while (countQ.size() > 0 && countQ[0].due <= edgeCount) begin
        it       = countQ.pop_front();
        expCount = it.val[7:0];
      end
      while (histQ.size() > 0 && histQ[0].due <= edgeCount) begin
        it      = histQ.pop_front();
        expHist = it.val;
      end
      expDigit = (edgeCount / SCAN_DIV) % ND;
      expAn    = ~(4'b0001 << expDigit);
      nib      = expHist[4*expDigit +: 4];
      checkOutput("an", 16'(bus.an), 16'(expAn));
      checkOutput("seg", 16'(bus.seg), 16'(glyph[nib]));
      checkOutput("byte_count", 16'(bus.byte_count), 16'(expCount));
    end
  end

  initial begin
    logic [7:0] d;
    int         digitNow;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.clear      = 1'b0;
    flushModel();
    #23;
    @(negedge clock);
    reset = 1'b0;

    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0);

    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);

    doReset();
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'h2A, 1'b0);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);

    doReset();
    applyStimulus(1'b1, 8'h5A, 1'b1);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      d = 8'(i);
      if (d == 8'hF0) d = 8'h0F;
      applyStimulus(1'b1, d, 1'b0);
    end
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);

    // Asynchronous reset while digit 2 is lit and a break prefix is pending.
    doReset();
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 40 && ((edgeCount / SCAN_DIV) % ND) != 2; k++)
      applyStimulus(1'b0, 8'h00, 1'b0);
    digitNow = (edgeCount / SCAN_DIV) % ND;
    checkOutput("reach_digit2", 16'(digitNow), 16'd2);
    #2 reset = 1'b1;
    flushModel();
    #1;
    checkOutput("rst_an", 16'(bus.an), 16'h000E);
    checkOutput("rst_seg", 16'(bus.seg), 16'h0040);
    checkOutput("rst_count", 16'(bus.byte_count), 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h33, 1'b0);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);

    doReset();
    for (int i = 0; i < 1500; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      applyStimulus($urandom_range(0, 2) != 0, d, $urandom_range(0, 39) == 0);
    end
    repeat (30) applyStimulus(1'b0, 8'h00, 1'b0);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scancode_display.md
SCANCODE_DISPLAY -- requirements
Module: scancode_display

Interface
REQ-001 Parameter NBYTES, default 2: number of received bytes retained and displayed (1..4); digit count ND = 2*NBYTES.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit stays selected (>=2).
REQ-003 FPGA_clock  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_valid  input  1  one-cycle strobe; data_in valid in the same cycle.
REQ-006 data_in  input  8  received scancode byte.
REQ-007 clear  input  1  synchronous clear of history and byte count.
REQ-008 seg  output  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-009 an  output  ND  digit enables, active-low, exactly one bit low.
REQ-010 byte_count  output  8  saturating count of stored bytes.

Function
REQ-011 History register hist is NBYTES*8 bits; a stored byte shifts hist left by 8 and enters at hist[7:0].
REQ-012 A byte is stored in the cycle after the data_valid strobe (hist updated at edge N+1 for a strobe in cycle N).
REQ-013 Digit d (0..ND-1) displays hist[4d+3:4d] as hex 0-F, standard 7-segment glyphs ("b" and "d" lower-case).
REQ-014 Prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit index advances by 1; index wraps ND-1 -> 0.
REQ-015 seg and an are registered together from the same digit index; they never disagree for a cycle.
REQ-016 Display latency: a byte strobed in cycle N is visible on seg no later than edge N+2 if its digit is selected.
REQ-017 byte_count increments by 1 per stored byte; it saturates at 255 and holds.
REQ-018 clear asserted: hist <= 0, byte_count <= 0 and break FSM <= IDLE on the next edge; prescaler and scan are unaffected.
REQ-019 clear and data_valid in the same cycle: clear wins; the byte is dropped.
REQ-020 data_valid strobes on consecutive cycles are each stored; no strobe is lost.

Reset
REQ-021 rst asserted: hist=0, byte_count=0, prescaler=0, digit index=0, break FSM=IDLE, an = all ones except an[0]=0, seg=7'b1000000 (glyph "0"), all immediately and independent of the clock.
REQ-022 rst deasserted mid-scan or mid-break sequence: operation restarts from the reset state; no partial state survives.

Configuration
REQ-023 Macro SCANCODE_BREAK_FILTER_EN defined: break FSM with states IDLE and BREAK; in IDLE, byte 0xF0 moves to BREAK and is not stored; any other byte is stored. In BREAK, the next byte is discarded (not stored, not counted) and the FSM returns to IDLE; a 0xF0 received in BREAK is discarded and the FSM stays in BREAK.
REQ-024 Macro undefined: no FSM; every strobed byte, including 0xF0, is stored and counted.

Structure
REQ-025 Shared package scancode_pkg holds the 16-entry hex-to-segment constant table, the BREAK_CODE constant 8'hF0, and the break FSM state typedef.
REQ-026 Sub-module hex7seg: combinational 4-bit to 7-bit active-low decoder, instantiated once behind the digit multiplexer.

Verification (NBYTES=2, SCAN_DIV=4)
REQ-027 Reset then idle 16 cycles -> an cycles 1110,1101,1011,0111 every 4 cycles, seg=7'b1000000 throughout.
REQ-028 Strobe 0x1C then 0x32 -> hist=16'h1C32, byte_count=2; digit 0 shows "2" (7'b0100100), digit 3 shows "1" (7'b1111001).
REQ-029 With SCANCODE_BREAK_FILTER_EN: strobe 0x1C,0xF0,0x1C,0x2A -> hist=16'h1C2A, byte_count=2; without it: hist=16'h1C2A, byte_count=4.
REQ-030 Strobe 0x5A and assert clear in the same cycle -> hist stays 0, byte_count stays 0; then 300 strobes -> byte_count=255.
REQ-031 Assert rst asynchronously mid-digit 2 with the FSM in BREAK -> outputs match REQ-021 before the next edge; the next byte 0x33 is stored, not discarded.
